// File: rtl/axi_full_sram_slv.sv
// axi_full_sram_slv -- AXI4 slave in front of one on-chip SRAM (main-memory model).
//
// Independent write (W_IDLE -> W_DATA -> W_RESP) and read (R_IDLE -> R_DATA)
// engines. Each engine moves one data beat per cycle. Responses are always OKAY.
// The storage is the i_sram instance. Its array ram[0:2**AW-1] can be loaded
// through a hierarchical reference.
//
// Optional feature macro: AXI_SRAM_WRAP_EN
//   defined     : WRAP bursts wrap at the (LEN+1)*2**SIZE byte boundary
//   not defined : WRAP bursts advance like INCR
//
// Parameters: DW data width (power of two, >=16), AW word-address bits, IW ID width.
// Ports:
//   clock, reset                    single clock; synchronous active-high reset
//   MEM_AW* / MEM_AWVALID/AWREADY   write address channel
//   MEM_W*  / MEM_WVALID/WREADY     write data channel (WLAST is not used)
//   MEM_B*  / MEM_BVALID/BREADY     write response channel
//   MEM_AR* / MEM_ARVALID/ARREADY   read address channel
//   MEM_R*  / MEM_RVALID/RREADY     read data channel

module axi_sram_array #(
  parameter int DW = 128,
  parameter int AW = 14
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_strb,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);
  logic [DW-1:0] ram [0:2**AW-1];

  // Byte-masked write port; the contents are never cleared
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wr_strb[b]) ram[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read port; on a same-edge collision the old word is returned
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= {DW{1'b0}};
    end else if (rd_en) begin
      rd_data <= ram[rd_addr];
    end
  end
endmodule

module axi_full_sram_slv #(
  parameter int DW = 128,
  parameter int AW = 14,
  parameter int IW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IW-1:0]   MEM_AWID,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  output logic [IW-1:0]   MEM_BID,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  input  logic [IW-1:0]   MEM_ARID,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  output logic [IW-1:0]   MEM_RID,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);
  localparam int OFF = $clog2(DW/8);
`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Address of the following beat. Burst 11 falls into the INCR default.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] wrap_mask;
    step      = 32'd1 << size;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = WRAP_EN ? ((addr & ~wrap_mask) | ((addr + step) & wrap_mask))
                                   : (addr + step);
      default: next_addr = addr + step;
    endcase
  endfunction

  w_state_t      w_state_r;
  logic          awready_r, wready_r, bvalid_r;
  logic [IW-1:0] bid_r;
  logic [31:0]   w_addr_r;
  logic [7:0]    w_len_r, w_cnt_r;
  logic [2:0]    w_size_r;
  logic [1:0]    w_burst_r;

  r_state_t      r_state_r;
  logic          arready_r, rvalid_r, rlast_r;
  logic [IW-1:0] rid_r;
  logic [31:0]   r_addr_r;
  logic [7:0]    r_len_r, r_cnt_r;
  logic [2:0]    r_size_r;
  logic [1:0]    r_burst_r;

  logic [31:0]   w_next_s, r_next_s;
  logic          wr_en_s, rd_en_s;
  logic [AW-1:0] rd_word_s;
  logic [DW-1:0] rd_data_s;
  logic          unused_ok_s;

  assign w_next_s    = next_addr(w_addr_r, w_len_r, w_size_r, w_burst_r);
  assign r_next_s    = next_addr(r_addr_r, r_len_r, r_size_r, r_burst_r);
  assign wr_en_s     = (w_state_r == W_DATA) && wready_r && MEM_WVALID;
  assign unused_ok_s = MEM_WLAST;

  // Read fetch: load beat 0 when entering R_DATA, then prefetch on each accepted beat
  always_comb begin
    rd_en_s   = 1'b0;
    rd_word_s = r_addr_r[AW+OFF-1:OFF];
    if ((r_state_r == R_DATA) && !rvalid_r) begin
      rd_en_s   = 1'b1;
      rd_word_s = r_addr_r[AW+OFF-1:OFF];
    end else if ((r_state_r == R_DATA) && MEM_RREADY && !rlast_r) begin
      rd_en_s   = 1'b1;
      rd_word_s = r_next_s[AW+OFF-1:OFF];
    end else begin
      rd_en_s   = 1'b0;
      rd_word_s = r_addr_r[AW+OFF-1:OFF];
    end
  end

  axi_sram_array #(.DW(DW), .AW(AW)) i_sram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (w_addr_r[AW+OFF-1:OFF]),
    .wr_data (MEM_WDATA),
    .wr_strb (MEM_WSTRB),
    .rd_en   (rd_en_s),
    .rd_addr (rd_word_s),
    .rd_data (rd_data_s)
  );

  // Write engine: address capture, one beat per cycle, then hold B until accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {IW{1'b0}};
      w_addr_r  <= 32'd0;
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (MEM_AWVALID && awready_r) begin
            bid_r     <= MEM_AWID;
            w_addr_r  <= MEM_AWADDR;
            w_len_r   <= MEM_AWLEN;
            w_size_r  <= MEM_AWSIZE;
            w_burst_r <= MEM_AWBURST;
            w_cnt_r   <= 8'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          // The beat count closes the burst; WLAST is deliberately ignored
          if (MEM_WVALID && wready_r) begin
            if (w_cnt_r == w_len_r) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              w_state_r <= W_RESP;
            end else begin
              w_addr_r <= w_next_s;
              w_cnt_r  <= w_cnt_r + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (MEM_BREADY) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read engine: RVALID follows the first fetch; RLAST tracks the beat counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {IW{1'b0}};
      r_addr_r  <= 32'd0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (MEM_ARVALID && arready_r) begin
            rid_r     <= MEM_ARID;
            r_addr_r  <= MEM_ARADDR;
            r_len_r   <= MEM_ARLEN;
            r_size_r  <= MEM_ARSIZE;
            r_burst_r <= MEM_ARBURST;
            r_cnt_r   <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            r_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (!rvalid_r) begin
            rvalid_r <= 1'b1;
            rlast_r  <= (r_len_r == 8'd0);
          end else if (MEM_RREADY) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              r_addr_r <= r_next_s;
              r_cnt_r  <= r_cnt_r + 8'd1;
              rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_AWREADY = awready_r;
  assign MEM_WREADY  = wready_r;
  assign MEM_BVALID  = bvalid_r;
  assign MEM_BID     = bid_r;
  assign MEM_BRESP   = 2'b00;
  assign MEM_ARREADY = arready_r;
  assign MEM_RVALID  = rvalid_r;
  assign MEM_RLAST   = rlast_r;
  assign MEM_RID     = rid_r;
  assign MEM_RDATA   = rd_data_s;
  assign MEM_RRESP   = 2'b00;
endmodule

// File: tb/tb_axi_full_sram_slv.sv
// Self-checking bench for axi_full_sram_slv.
// A word-array model of the SRAM region 0..NW-1 predicts every read beat.
// Beat addresses are derived from the AXI burst rules with plain arithmetic.
module tb_axi_full_sram_slv;
  localparam int DW = 128;
  localparam int AW = 14;
  localparam int IW = 8;
  localparam int NW = 64;
`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [IW-1:0] MEM_AWID = '0;  logic [31:0] MEM_AWADDR = '0; logic [7:0] MEM_AWLEN = '0;
  logic [2:0] MEM_AWSIZE = '0;   logic [1:0] MEM_AWBURST = '0; logic MEM_AWVALID = 1'b0;
  logic MEM_AWREADY;
  logic [DW-1:0] MEM_WDATA = '0; logic [DW/8-1:0] MEM_WSTRB = '0;
  logic MEM_WLAST = 1'b0, MEM_WVALID = 1'b0;
  logic MEM_WREADY;
  logic [IW-1:0] MEM_BID; logic [1:0] MEM_BRESP; logic MEM_BVALID; logic MEM_BREADY = 1'b0;
  logic [IW-1:0] MEM_ARID = '0;  logic [31:0] MEM_ARADDR = '0; logic [7:0] MEM_ARLEN = '0;
  logic [2:0] MEM_ARSIZE = '0;   logic [1:0] MEM_ARBURST = '0; logic MEM_ARVALID = 1'b0;
  logic MEM_ARREADY;
  logic [IW-1:0] MEM_RID; logic [DW-1:0] MEM_RDATA; logic [1:0] MEM_RRESP;
  logic MEM_RLAST, MEM_RVALID; logic MEM_RREADY = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0]   model [0:NW-1];
  logic [DW-1:0]   wd [0:15];
  logic [DW/8-1:0] ws [0:15];

  axi_full_sram_slv #(.DW(DW), .AW(AW), .IW(IW)) dut (
    .clock(clock), .reset(reset),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB),
    .MEM_WLAST(MEM_WLAST), .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
    .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY), .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA),
    .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID),
    .MEM_RREADY(MEM_RREADY)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Word index touched by beat n of a burst, derived from the AXI addressing rules
  function automatic int beat_word(input logic [31:0] start, input int n, input int len,
                                   input int size, input int burst);
    longint s, sz, bytes, base, a;
    s  = longint'(start);
    sz = 1;
    sz = sz << size;
    if (burst == 0) a = s;
    else if (burst == 2 && WRAP_ON) begin
      bytes = (len + 1) * sz;
      base  = s - (s % bytes);
      a     = base + ((s - base + n * sz) % bytes);
    end else a = s + n * sz;
    return int'((a / (DW/8)) % (longint'(1) << AW));
  endfunction

  task automatic send_aw(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = len[7:0]; MEM_AWSIZE = size;
    MEM_AWBURST = burst; MEM_AWVALID = 1'b1;
    while (MEM_AWREADY !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    tests++;
    if (MEM_AWREADY !== 1'b1) begin fails++; $display("FAIL aw_handshake got=%b want=1", MEM_AWREADY); end
    @(posedge clock); #1;
    MEM_AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = len[7:0]; MEM_ARSIZE = size;
    MEM_ARBURST = burst; MEM_ARVALID = 1'b1;
    while (MEM_ARREADY !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    tests++;
    if (MEM_ARREADY !== 1'b1) begin fails++; $display("FAIL ar_handshake got=%b want=1", MEM_ARREADY); end
    @(posedge clock); #1;
    MEM_ARVALID = 1'b0;
  endtask

  // Full write transaction using wd/ws; the model is updated beat by beat
  task automatic write_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input bit gaps);
    int n, w;
    send_aw(id, addr, len, size, burst);
    tests++;
    if (MEM_WREADY !== 1'b1) begin fails++; $display("FAIL wready_after_aw got=%b want=1", MEM_WREADY); end
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin MEM_WVALID = 1'b0; @(posedge clock); #1; end
      MEM_WDATA = wd[b]; MEM_WSTRB = ws[b]; MEM_WLAST = (b == len); MEM_WVALID = 1'b1;
      n = 0;
      while (MEM_WREADY !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1;
      w = beat_word(addr, b, len, int'(size), int'(burst));
      for (int k = 0; k < DW/8; k++) if (ws[b][k]) model[w][k*8 +: 8] = wd[b][k*8 +: 8];
      tests++;
      if (MEM_BVALID !== (b == len)) begin
        fails++; $display("FAIL bvalid_timing beat=%0d got=%b want=%b", b, MEM_BVALID, b == len);
      end
    end
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    tests++;
    if (MEM_BVALID !== 1'b1 || MEM_BID !== id || MEM_BRESP !== 2'b00) begin
      fails++; $display("FAIL b_resp got v=%b id=%h resp=%b want v=1 id=%h resp=00", MEM_BVALID, MEM_BID, MEM_BRESP, id);
    end
    MEM_BREADY = 1'b1; @(posedge clock); #1; MEM_BREADY = 1'b0;
    tests++;
    if (MEM_BVALID !== 1'b0 || MEM_AWREADY !== 1'b1) begin
      fails++; $display("FAIL b_done got bvalid=%b awready=%b want 0/1", MEM_BVALID, MEM_AWREADY);
    end
  endtask

  // Full read transaction; mode 0 = RREADY always high, 1 = toggling, 2 = random
  task automatic read_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode,
                            output int first, output int cyc);
    int got, w;
    logic rr;
    send_ar(id, addr, len, size, burst);
    tests++;
    if (MEM_RVALID !== 1'b0) begin fails++; $display("FAIL r_early got=%b want=0", MEM_RVALID); end
    got = 0; cyc = 0; first = -1;
    while (got <= len && cyc < 400) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      MEM_RREADY = rr;
      if (MEM_RVALID === 1'b1) begin
        if (first < 0) first = cyc;
        w = beat_word(addr, got, len, int'(size), int'(burst));
        tests++;
        if (MEM_RDATA !== model[w] || MEM_RLAST !== (got == len) || MEM_RID !== id || MEM_RRESP !== 2'b00) begin
          fails++;
          $display("FAIL r_beat %0d got data=%h last=%b id=%h resp=%b want data=%h last=%b id=%h resp=00",
                   got, MEM_RDATA, MEM_RLAST, MEM_RID, MEM_RRESP, model[w], got == len, id);
        end
        if (rr) got++;
      end
      tests++;
      if (MEM_ARREADY !== 1'b0) begin fails++; $display("FAIL arready_busy got=%b want=0", MEM_ARREADY); end
      @(posedge clock); #1; cyc++;
    end
    MEM_RREADY = 1'b0;
    tests++;
    if (got != len + 1) begin fails++; $display("FAIL r_beats got=%0d want=%0d", got, len + 1); end
    tests++;
    if (MEM_RVALID !== 1'b0 || MEM_ARREADY !== 1'b1) begin
      fails++; $display("FAIL r_done got rvalid=%b arready=%b want 0/1", MEM_RVALID, MEM_ARREADY);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({MEM_AWREADY, MEM_WREADY, MEM_BVALID, MEM_ARREADY, MEM_RVALID, MEM_RLAST,
         MEM_BID, MEM_RID, MEM_RDATA, MEM_BRESP, MEM_RRESP} !== '0) begin
      fails++; $display("FAIL reset_outputs got rdata=%h aw=%b ar=%b want all zero", MEM_RDATA, MEM_AWREADY, MEM_ARREADY);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (MEM_AWREADY !== 1'b1 || MEM_ARREADY !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset got aw=%b ar=%b want 1/1", MEM_AWREADY, MEM_ARREADY);
    end
  endtask

  task automatic test_single_read();
    int first, cyc;
    read_burst(8'h5A, 32'h8000_0000, 0, 3'd4, 2'b01, 0, first, cyc);
    tests++;
    if (first != 1) begin fails++; $display("FAIL read_latency got=%0d want=1", first); end
  endtask

  task automatic test_incr_burst();
    int first, cyc;
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    write_burst(8'h3C, 32'h8000_0010, 3, 3'd4, 2'b01, 1'b0);
    read_burst(8'hC3, 32'h8000_0010, 3, 3'd4, 2'b01, 0, first, cyc);
    tests++;
    if (cyc != 5) begin fails++; $display("FAIL incr_back_to_back got=%0d cycles want=5", cyc); end
  endtask

  task automatic test_strobe();
    int first, cyc;
    wd[0] = {$urandom, $urandom, $urandom, $urandom};
    wd[0][7:0] = 8'hAB;
    ws[0] = 16'h0001;
    write_burst(8'h11, 32'h0000_0050, 0, 3'd4, 2'b01, 1'b0);
    read_burst(8'h12, 32'h0000_0050, 0, 3'd4, 2'b01, 0, first, cyc);
  endtask

  task automatic test_stall_read();
    int first, cyc;
    read_burst(8'h77, 32'h0000_0080, 7, 3'd4, 2'b01, 1, first, cyc);
  endtask

  task automatic test_wrap();
    int first, cyc;
    read_burst(8'h21, 32'h8000_0020, 3, 3'd4, 2'b10, 0, first, cyc);
    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    write_burst(8'h22, 32'h0000_0130, 1, 3'd4, 2'b10, 1'b0);
    read_burst(8'h23, 32'h0000_0120, 3, 3'd4, 2'b01, 0, first, cyc);
  endtask

  // AW and AR to the same word accepted on one edge: data write and read fetch coincide
  task automatic test_collision();
    int first, cyc;
    logic [DW-1:0] old_v, new_v;
    old_v = model[5];
    new_v = {$urandom, $urandom, $urandom, $urandom};
    MEM_AWID = 8'h41; MEM_AWADDR = 32'h50; MEM_AWLEN = 8'd0; MEM_AWSIZE = 3'd4; MEM_AWBURST = 2'b01;
    MEM_ARID = 8'h42; MEM_ARADDR = 32'h50; MEM_ARLEN = 8'd0; MEM_ARSIZE = 3'd4; MEM_ARBURST = 2'b01;
    MEM_WDATA = new_v; MEM_WSTRB = '1; MEM_WLAST = 1'b1;
    MEM_AWVALID = 1'b1; MEM_ARVALID = 1'b1; MEM_WVALID = 1'b1;
    tests++;
    if (MEM_AWREADY !== 1'b1 || MEM_ARREADY !== 1'b1) begin
      fails++; $display("FAIL collide_idle got aw=%b ar=%b want 1/1", MEM_AWREADY, MEM_ARREADY);
    end
    @(posedge clock); #1;
    MEM_AWVALID = 1'b0; MEM_ARVALID = 1'b0; MEM_RREADY = 1'b1;
    @(posedge clock); #1;
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
    tests++;
    if (MEM_RVALID !== 1'b1 || MEM_RDATA !== old_v || MEM_BVALID !== 1'b1) begin
      fails++; $display("FAIL collide_old_data got rvalid=%b data=%h bvalid=%b want 1 %h 1", MEM_RVALID, MEM_RDATA, MEM_BVALID, old_v);
    end
    MEM_BREADY = 1'b1;
    @(posedge clock); #1;
    MEM_BREADY = 1'b0; MEM_RREADY = 1'b0;
    model[5] = new_v;
    read_burst(8'h43, 32'h50, 0, 3'd4, 2'b01, 0, first, cyc);
  endtask

  task automatic test_random();
    int first, cyc, sz, bu, ln, wrd, off;
    logic [31:0] a;
    for (int it = 0; it < 40; it++) begin
      sz  = $urandom_range(2, 4);
      bu  = $urandom_range(0, 3);
      ln  = (bu == 2) ? ((2 << $urandom_range(0, 2)) - 1) : $urandom_range(0, 7);
      wrd = $urandom_range(0, 48);
      off = $urandom_range(0, (16 >> sz) - 1) * (1 << sz);
      a   = (32'($urandom) & 32'hFFFC_0000) | 32'(wrd * 16 + off);
      if (it % 2 == 0) begin
        for (int i = 0; i <= ln; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'($urandom); end
        write_burst(8'($urandom), a, ln, 3'(sz), 2'(bu), 1'b1);
      end else begin
        read_burst(8'($urandom), a, ln, 3'(sz), 2'(bu), 2, first, cyc);
      end
    end
  endtask

  task automatic test_concurrent();
    int first, cyc;
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    fork
      write_burst(8'h61, 32'h0000_0040, 7, 3'd4, 2'b01, 1'b1);
      read_burst(8'h62, 32'h8000_0280, 7, 3'd4, 2'b01, 2, first, cyc);
    join
  endtask

  task automatic test_reset_mid_burst();
    int first, cyc;
    send_aw(8'h99, 32'h0000_0140, 3, 3'd4, 2'b01);
    for (int b = 0; b < 2; b++) begin
      MEM_WDATA = {$urandom, $urandom, $urandom, $urandom}; MEM_WSTRB = '1; MEM_WVALID = 1'b1;
      @(posedge clock); #1;
      model[20 + b] = MEM_WDATA;
    end
    MEM_WVALID = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({MEM_AWREADY, MEM_WREADY, MEM_BVALID, MEM_ARREADY, MEM_RVALID, MEM_RLAST,
         MEM_BID, MEM_RID, MEM_RDATA, MEM_BRESP, MEM_RRESP} !== '0) begin
      fails++; $display("FAIL midburst_reset got wready=%b bid=%h rdata=%h want all zero", MEM_WREADY, MEM_BID, MEM_RDATA);
    end
    reset = 1'b0;
    MEM_BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      tests++;
      if (MEM_BVALID !== 1'b0 || MEM_WREADY !== 1'b0) begin
        fails++; $display("FAIL dropped_burst got bvalid=%b wready=%b want 0/0", MEM_BVALID, MEM_WREADY);
      end
    end
    MEM_BREADY = 1'b0;
    read_burst(8'h9A, 32'h0000_0120, 5, 3'd4, 2'b01, 0, first, cyc);
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < NW; i++) begin
      model[i] = {$urandom, $urandom, $urandom, $urandom};
      dut.i_sram.ram[i] <= model[i];
    end
    model[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    dut.i_sram.ram[0] <= 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    @(posedge clock); #1;
    test_single_read();
    test_incr_burst();
    test_strobe();
    test_stall_read();
    test_wrap();
    test_collision();
    test_random();
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
